// File: rtl/ntt_io_pkg.sv
// Shared widths and payload types for the NTT result I/O path.
package ntt_io_pkg;

  localparam int unsigned NTT_COEF_W         = 16;
  localparam int unsigned NTT_BEAT_W         = 128;
  localparam int unsigned NTT_OUT_W          = 32;
  localparam int unsigned NTT_WORDS_PER_BEAT = 4;
  localparam int unsigned NTT_BEATS_PER_POLY = 64;
  localparam int unsigned NTT_CNT_W          = 7;
  localparam int unsigned NTT_FIFO_DEPTH     = 2;
  localparam int unsigned NTT_WIDX_W         = $clog2(NTT_WORDS_PER_BEAT);

  // One buffered result beat together with its end-of-polynomial flag.
  typedef struct packed {
    logic                  lst;
    logic [NTT_BEAT_W-1:0] beat;
  } beat_entry_t;

  // Select output word idx of a beat, lowest word first.
  function automatic logic [NTT_OUT_W-1:0] beat_word(input logic [NTT_BEAT_W-1:0] beat,
                                                     input logic [NTT_WIDX_W-1:0] idx);
    return beat[idx*NTT_OUT_W +: NTT_OUT_W];
  endfunction

endpackage

// File: rtl/ntt_out_serializer_if.sv
// Result-beat input stream, 32-bit output stream and status of the serializer.
interface ntt_out_serializer_if;
  import ntt_io_pkg::*;

  logic                  sw_vld;
  logic                  sw_rdy;
  logic [NTT_BEAT_W-1:0] sw_dat;
  logic                  sw_lst;
  logic                  m_tvalid;
  logic                  m_tready;
  logic [NTT_OUT_W-1:0]  m_tdata;
  logic                  m_tlast;
  logic                  busy;
  logic                  len_err;
  logic [NTT_CNT_W-1:0]  beat_cnt;

  // Environment side: drives beats in, accepts words out.
  modport master (
    output sw_vld, sw_dat, sw_lst, m_tready,
    input  sw_rdy, m_tvalid, m_tdata, m_tlast, busy, len_err, beat_cnt
  );

  // Serializer side.
  modport slave (
    input  sw_vld, sw_dat, sw_lst, m_tready,
    output sw_rdy, m_tvalid, m_tdata, m_tlast, busy, len_err, beat_cnt
  );

endinterface

// File: rtl/ntt_beat_fifo.sv
// Two-entry register FIFO of result beats; slot 0 is always the head.
module ntt_beat_fifo
  import ntt_io_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  beat_entry_t push_data_i,
  input  logic        pop_i,
  output logic        full_o,
  output logic        empty_o,
  output beat_entry_t head_o
);

  localparam int unsigned CNT_W = $clog2(NTT_FIFO_DEPTH + 1);

  beat_entry_t      slot0_q, slot0_d;
  beat_entry_t      slot1_q, slot1_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, empty_q;
  logic             do_push, do_pop;

  assign do_push = push_i & ~full_q;
  assign do_pop  = pop_i & ~empty_q;

  // Push+pop together can only happen at occupancy 1: the new beat becomes head.
  always_comb begin
    slot0_d = slot0_q;
    slot1_d = slot1_q;
    cnt_d   = cnt_q;
    case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == '0) slot0_d = push_data_i;
        else             slot1_d = push_data_i;
        cnt_d = CNT_W'(cnt_q + 1'b1);
      end
      2'b01: begin
        slot0_d = slot1_q;
        cnt_d   = CNT_W'(cnt_q - 1'b1);
      end
      2'b11: begin
        slot0_d = push_data_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot0_q <= '0;
      slot1_q <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      slot0_q <= slot0_d;
      slot1_q <= slot1_d;
      cnt_q   <= cnt_d;
      full_q  <= (cnt_d == CNT_W'(NTT_FIFO_DEPTH));
      empty_q <= (cnt_d == '0);
    end
  end

  assign full_o  = full_q;
  assign empty_o = empty_q;
  assign head_o  = slot0_q;

endmodule

// File: rtl/ntt_out_serializer.sv
// Splits 128-bit kernel result beats into 32-bit words and checks polynomial length.
module ntt_out_serializer
  import ntt_io_pkg::*;
#(
  parameter int unsigned pDATA_WIDTH = NTT_BEAT_W,
  parameter int unsigned pOUT_WIDTH  = NTT_OUT_W,
  parameter int unsigned pBEATS      = NTT_BEATS_PER_POLY
) (
  input  logic                 clk,
  input  logic                 rst,
  ntt_out_serializer_if.slave  bus
);

  localparam int unsigned WORDS     = pDATA_WIDTH / pOUT_WIDTH;
  localparam int unsigned WIDX_W    = $clog2(WORDS);
  localparam int unsigned CNT_W     = NTT_CNT_W;
  localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(WORDS - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(pBEATS - 1);

  logic [WIDX_W-1:0] widx_q, widx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic        fifo_full, fifo_empty;
  logic        push, pop, xfer, last_word;
  beat_entry_t push_entry, head;

  assign push      = bus.sw_vld & ~fifo_full;
  assign xfer      = ~fifo_empty & bus.m_tready;
  assign last_word = (widx_q == WIDX_LAST);
  assign pop       = xfer & last_word;

  assign push_entry.lst  = bus.sw_lst;
  assign push_entry.beat = bus.sw_dat;

  ntt_beat_fifo u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (push_entry),
    .pop_i       (pop),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .head_o      (head)
  );

  // Word index and length checker; m_tlast never depends on the counter.
  always_comb begin
    widx_d = widx_q;
    cnt_d  = cnt_q;
    err_d  = err_q;
    if (xfer) begin
      widx_d = last_word ? '0 : WIDX_W'(widx_q + 1'b1);
    end
    if (push) begin
      if (bus.sw_lst) begin
        if (cnt_q != CNT_LAST) err_d = 1'b1;
        cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
        err_d = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = CNT_W'(cnt_q + 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      widx_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      widx_q <= widx_d;
      cnt_q  <= cnt_d;
      err_q  <= err_d;
    end
  end

  // All outputs decode registered state only; nothing flows through from sw_vld or m_tready.
  assign bus.sw_rdy   = ~fifo_full;
  assign bus.m_tvalid = ~fifo_empty;
  assign bus.busy     = ~fifo_empty;
  assign bus.m_tdata  = beat_word(head.beat, NTT_WIDX_W'(widx_q));
  assign bus.m_tlast  = head.lst & last_word;
  assign bus.len_err  = err_q;
  assign bus.beat_cnt = cnt_q;

endmodule

// File: tb/tb_ntt_out_serializer.sv
// Directed bench for ntt_out_serializer: vector table plus multi-cycle stream sequences.
module tb_ntt_out_serializer;
  import ntt_io_pkg::*;

  typedef struct {
    logic [127:0] dat;
    logic [31:0]  w[4];
    logic [6:0]   cnt;
  } vec_t;

  typedef struct {
    logic [127:0] dat;
    logic         lst;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic        l;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ntt_out_serializer_if bus ();

  ntt_out_serializer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  vec_t        tbl[4];
  beat_t       send_q[$];
  word_t       exp_q[$];
  int          n_vec = 0;
  int          n_err = 0;
  int          m_cnt = 0;
  logic        m_err = 1'b0;
  logic [31:0] last_word = '0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int i, input logic [127:0] d, input logic [31:0] w0,
                         input logic [31:0] w1, input logic [31:0] w2, input logic [31:0] w3,
                         input logic [6:0] c);
    tbl[i].dat  = d;
    tbl[i].w[0] = w0;
    tbl[i].w[1] = w1;
    tbl[i].w[2] = w2;
    tbl[i].w[3] = w3;
    tbl[i].cnt  = c;
  endtask

  function automatic logic [127:0] ramp_beat(input int b);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 8; j++) r[j*16 +: 16] = 16'(b*8 + j);
    return r;
  endfunction

  // Beat b carries coefficients 8b..8b+7; word k holds coefficients 8b+2k (low) and 8b+2k+1.
  task automatic add_beat(input int b, input logic lst);
    beat_t e;
    word_t w;
    e.dat = ramp_beat(b);
    e.lst = lst;
    send_q.push_back(e);
    for (int k = 0; k < 4; k++) begin
      w.d = {16'(b*8 + 2*k + 1), 16'(b*8 + 2*k)};
      w.l = lst && (k == 3);
      exp_q.push_back(w);
    end
  endtask

  task automatic model_accept(input logic lst);
    if (lst) begin
      if (m_cnt != 63) m_err = 1'b1;
      m_cnt = 0;
    end else if (m_cnt == 63) begin
      m_err = 1'b1;
      m_cnt = 0;
    end else begin
      m_cnt = m_cnt + 1;
    end
  endtask

  task automatic do_reset(input bit chk);
    rst = 1'b1;
    bus.sw_vld   = 1'b0;
    bus.sw_lst   = 1'b0;
    bus.sw_dat   = '0;
    bus.m_tready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    if (chk) begin
      check("rst_sw_rdy",   bus.sw_rdy,   1'b1);
      check("rst_m_tvalid", bus.m_tvalid, 1'b0);
      check("rst_m_tdata",  bus.m_tdata,  32'h0);
      check("rst_m_tlast",  bus.m_tlast,  1'b0);
      check("rst_busy",     bus.busy,     1'b0);
      check("rst_len_err",  bus.len_err,  1'b0);
      check("rst_beat_cnt", bus.beat_cnt, 7'd0);
    end
    rst = 1'b0;
    m_cnt = 0;
    m_err = 1'b0;
    send_q.delete();
    exp_q.delete();
  endtask

  // Streams send_q through the DUT; m_tready held low for the first 'stall' cycles.
  task automatic run_stream(input int stall, input int stop_words, input int max_cyc);
    int          cyc = 0;
    int          acc = 0;
    int          words = 0;
    logic        pv = 1'b0;
    logic [31:0] pd = '0;
    logic        pl = 1'b0;
    logic        acc_now, xfer_now, lst_now;
    word_t       e;
    while ((send_q.size() > 0 || exp_q.size() > 0) && cyc < max_cyc) begin
      if (send_q.size() > 0) begin
        bus.sw_vld = 1'b1;
        bus.sw_dat = send_q[0].dat;
        bus.sw_lst = send_q[0].lst;
      end else begin
        bus.sw_vld = 1'b0;
        bus.sw_lst = 1'b0;
      end
      bus.m_tready = (cyc >= stall);
      if (stall > 0 && cyc == stall) begin
        check("bp_accepted", 32'(acc), 32'd2);
        check("bp_sw_rdy",   bus.sw_rdy,   1'b0);
        check("bp_m_tvalid", bus.m_tvalid, 1'b1);
        check("bp_m_tdata",  bus.m_tdata,  32'h00010000);
      end
      if (pv) begin
        check("hold_tdata", bus.m_tdata, pd);
        check("hold_tlast", bus.m_tlast, pl);
      end
      pv = bus.m_tvalid && !bus.m_tready;
      pd = bus.m_tdata;
      pl = bus.m_tlast;
      acc_now  = bus.sw_vld && bus.sw_rdy;
      lst_now  = bus.sw_lst;
      xfer_now = bus.m_tvalid && bus.m_tready;
      if (xfer_now) begin
        if (exp_q.size() == 0) begin
          check("extra_word", bus.m_tdata, 32'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          check("word_data", bus.m_tdata, e.d);
          check("word_last", bus.m_tlast, e.l);
        end
        last_word = bus.m_tdata;
        words++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (acc_now) begin
        void'(send_q.pop_front());
        acc++;
        model_accept(lst_now);
        check("acc_beat_cnt", bus.beat_cnt, 7'(m_cnt));
        check("acc_len_err",  bus.len_err,  m_err);
      end
      if (stop_words > 0 && words == stop_words) break;
    end
    bus.sw_vld = 1'b0;
    bus.sw_lst = 1'b0;
    if (cyc >= max_cyc) begin
      n_vec++;
      n_err++;
      $display("FAIL stream_timeout: %0d beats and %0d words still pending after %0d cycles",
               send_q.size(), exp_q.size(), cyc);
    end else if (stop_words == 0) begin
      check("idle_m_tvalid", bus.m_tvalid, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    set_vec(0, 128'h0007_0006_0005_0004_0003_0002_0001_0000,
            32'h00010000, 32'h00030002, 32'h00050004, 32'h00070006, 7'd1);
    set_vec(1, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF,
            32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 7'd2);
    set_vec(2, 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210,
            32'h76543210, 32'hFEDCBA98, 32'h89ABCDEF, 32'h01234567, 7'd3);
    set_vec(3, 128'h8000_0000_0000_0001_0000_0000_A5A5_A5A5,
            32'hA5A5A5A5, 32'h00000000, 32'h00000001, 32'h80000000, 7'd4);

    do_reset(1'b1);

    // Single beats: four words on consecutive cycles starting the cycle after accept.
    for (int i = 0; i < 4; i++) begin
      bus.sw_vld   = 1'b1;
      bus.sw_dat   = tbl[i].dat;
      bus.sw_lst   = 1'b0;
      bus.m_tready = 1'b1;
      check("tbl_sw_rdy", bus.sw_rdy, 1'b1);
      @(posedge clk);
      #1;
      bus.sw_vld = 1'b0;
      check("tbl_beat_cnt", bus.beat_cnt, tbl[i].cnt);
      for (int k = 0; k < 4; k++) begin
        check("tbl_m_tvalid", bus.m_tvalid, 1'b1);
        check("tbl_m_tdata",  bus.m_tdata,  tbl[i].w[k]);
        check("tbl_m_tlast",  bus.m_tlast,  1'b0);
        @(posedge clk);
        #1;
      end
      check("tbl_drained", bus.m_tvalid, 1'b0);
      check("tbl_busy",    bus.busy,     1'b0);
    end
    check("tbl_len_err", bus.len_err, 1'b0);

    // Full polynomial of 64 beats at full output rate.
    do_reset(1'b0);
    for (int b = 0; b < 64; b++) add_beat(b, b == 63);
    run_stream(0, 0, 2000);
    check("poly_last_word", last_word,    32'h01FF01FE);
    check("poly_len_err",   bus.len_err,  1'b0);
    check("poly_beat_cnt",  bus.beat_cnt, 7'd0);

    // Output stalled for 20 cycles while beats are offered.
    for (int b = 0; b < 64; b++) add_beat(b, b == 63);
    run_stream(20, 0, 3000);
    check("bp_len_err",  bus.len_err,  1'b0);
    check("bp_beat_cnt", bus.beat_cnt, 7'd0);

    // Short polynomial ending at beat 9, then a correct one.
    do_reset(1'b0);
    for (int b = 0; b < 10; b++) add_beat(b, b == 9);
    for (int b = 0; b < 64; b++) add_beat(b, b == 63);
    run_stream(0, 0, 3000);
    check("short_len_err",  bus.len_err,  1'b1);
    check("short_beat_cnt", bus.beat_cnt, 7'd0);

    // 65 beats without any sw_lst: counter wraps after beat 63.
    do_reset(1'b0);
    for (int b = 0; b < 65; b++) add_beat(b, 1'b0);
    run_stream(0, 0, 3000);
    check("long_len_err",  bus.len_err,  1'b1);
    check("long_beat_cnt", bus.beat_cnt, 7'd1);

    // Reset after word 2 of beat 5, then a fresh stream.
    do_reset(1'b0);
    for (int b = 0; b < 10; b++) add_beat(b, 1'b0);
    run_stream(0, 23, 1000);
    check("mid_pre_rst_valid", bus.m_tvalid, 1'b1);
    rst = 1'b1;
    bus.sw_vld = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_m_tvalid", bus.m_tvalid, 1'b0);
    check("mid_rst_busy",     bus.busy,     1'b0);
    check("mid_rst_beat_cnt", bus.beat_cnt, 7'd0);
    check("mid_rst_sw_rdy",   bus.sw_rdy,   1'b1);
    check("mid_rst_m_tdata",  bus.m_tdata,  32'h0);
    rst = 1'b0;
    send_q.delete();
    exp_q.delete();
    m_cnt = 0;
    m_err = 1'b0;
    add_beat(0, 1'b0);
    run_stream(0, 0, 100);
    check("mid_fresh_last_word", last_word, 32'h00070006);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
